fp_sub_pipe: RTL

- Pipelined bfloat16 subtractor computing result = op1 - op2. It is the inverse-direction companion to the team's combinational fp_add.
- Differences from fp_add:
  - registered 3-stage datapath
  - valid/ready handshake with backpressure
  - explicit special-value handling
  - deterministic normalization, including the exponent-decrease path
- Sits between the operand issue logic and the result writeback in the bfloat16 FPU.

---
 rtl/fp_sub_pipe.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_sub_pipe.sv
// Three-stage pipelined bfloat16 subtractor (result = op1 - op2) with valid/ready
// handshake; stages are unpack/classify/align, magnitude add/sub, normalize/pack.
module fp_sub_pipe #(
    parameter int  EXP_WIDTH  = 8,
    parameter int  FRAC_WIDTH = 7,
    localparam int W          = EXP_WIDTH + FRAC_WIDTH + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid
);

    localparam int MW  = FRAC_WIDTH + 1;
    localparam int SW  = MW + 1;
    localparam int XW  = EXP_WIDTH + 2;
    localparam int LZW = $clog2(MW + 1);

    localparam logic [EXP_WIDTH-1:0]  EXP_ONES  = {EXP_WIDTH{1'b1}};
    localparam logic [EXP_WIDTH-1:0]  EXP_ZERO  = {EXP_WIDTH{1'b0}};
    localparam logic [FRAC_WIDTH-1:0] FRAC_ZERO = {FRAC_WIDTH{1'b0}};
    localparam logic [W-1:0]          QNAN      = {1'b0, EXP_ONES, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
    localparam logic [W-1:0]          POS_ZERO  = {W{1'b0}};

    // Leading-zero count of a mantissa; returns MW for an all-zero input.
    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] m);
        logic [LZW-1:0] n;
        n = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (m[i]) begin
                n = LZW'(MW - 1 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic advance;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_spec_q, s1_spec_d;
    logic [W-1:0]         s1_spec_res_q, s1_spec_res_d;
    logic [2:0]           s1_spec_flg_q, s1_spec_flg_d;
    logic                 s1_sign_q, s1_sign_d;
    logic                 s1_sub_q, s1_sub_d;
    logic [EXP_WIDTH-1:0] s1_exp_q, s1_exp_d;
    logic [MW-1:0]        s1_big_q, s1_big_d;
    logic [MW-1:0]        s1_small_q, s1_small_d;

    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_spec_q, s2_spec_d;
    logic [W-1:0]         s2_spec_res_q, s2_spec_res_d;
    logic [2:0]           s2_spec_flg_q, s2_spec_flg_d;
    logic                 s2_sign_q, s2_sign_d;
    logic [EXP_WIDTH-1:0] s2_exp_q, s2_exp_d;
    logic [SW-1:0]        s2_sum_q, s2_sum_d;

    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         result_q, result_d;
    logic [2:0]           flags_q, flags_d;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = flags_q[2];
    assign underflow = flags_q[1];
    assign invalid   = flags_q[0];

    // S1: classify specials, order operands by magnitude and align the smaller one.
    always_comb begin
        logic                  sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        logic [EXP_WIDTH-1:0]  ea, eb, e_small, diff;
        logic [FRAC_WIDTH-1:0] fa, fb;
        logic [MW-1:0]         m_small;
        sa     = op1[W-1];
        sb     = ~op2[W-1];
        ea     = op1[W-2 -: EXP_WIDTH];
        eb     = op2[W-2 -: EXP_WIDTH];
        fa     = op1[FRAC_WIDTH-1:0];
        fb     = op2[FRAC_WIDTH-1:0];
        nan_a  = (ea == EXP_ONES) && (fa != FRAC_ZERO);
        nan_b  = (eb == EXP_ONES) && (fb != FRAC_ZERO);
        inf_a  = (ea == EXP_ONES) && (fa == FRAC_ZERO);
        inf_b  = (eb == EXP_ONES) && (fb == FRAC_ZERO);
        zero_a = (ea == EXP_ZERO);
        zero_b = (eb == EXP_ZERO);

        s1_spec_d     = 1'b1;
        s1_spec_res_d = POS_ZERO;
        s1_spec_flg_d = 3'b000;
        if (nan_a || nan_b) begin
            s1_spec_res_d = QNAN;
            s1_spec_flg_d = 3'b001;
        end else if (inf_a && inf_b) begin
            if (sa != sb) begin
                s1_spec_res_d = QNAN;
                s1_spec_flg_d = 3'b001;
            end else begin
                s1_spec_res_d = {sa, EXP_ONES, FRAC_ZERO};
            end
        end else if (inf_a) begin
            s1_spec_res_d = {sa, EXP_ONES, FRAC_ZERO};
        end else if (inf_b) begin
            s1_spec_res_d = {sb, EXP_ONES, FRAC_ZERO};
        end else if (zero_a && zero_b) begin
            s1_spec_res_d = POS_ZERO;
        end else if (zero_a) begin
            s1_spec_res_d = {sb, eb, fb};
        end else if (zero_b) begin
            s1_spec_res_d = {sa, ea, fa};
        end else begin
            s1_spec_d = 1'b0;
        end

        if ({ea, fa} >= {eb, fb}) begin
            s1_sign_d = sa;
            s1_exp_d  = ea;
            s1_big_d  = {1'b1, fa};
            e_small   = eb;
            m_small   = {1'b1, fb};
        end else begin
            s1_sign_d = sb;
            s1_exp_d  = eb;
            s1_big_d  = {1'b1, fb};
            e_small   = ea;
            m_small   = {1'b1, fa};
        end
        diff = s1_exp_d - e_small;
        if (diff >= EXP_WIDTH'(MW)) begin
            s1_small_d = {MW{1'b0}};
        end else begin
            s1_small_d = m_small >> diff;
        end
        s1_sub_d   = sa ^ sb;
        s1_valid_d = advance ? in_valid : s1_valid_q;
    end

    // S2: magnitude add or subtract; the big operand is never smaller, so no borrow.
    always_comb begin
        if (s1_sub_q) begin
            s2_sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
        end else begin
            s2_sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
        end
        s2_valid_d    = advance ? s1_valid_q : s2_valid_q;
        s2_spec_d     = s1_spec_q;
        s2_spec_res_d = s1_spec_res_q;
        s2_spec_flg_d = s1_spec_flg_q;
        s2_sign_d     = s1_sign_q;
        s2_exp_d      = s1_exp_q;
    end

    // S3: normalize, range-check and pack; the output register only changes on advance.
    always_comb begin
        logic signed [XW-1:0] exp_n;
        logic [MW-1:0]        mant_n;
        logic [LZW-1:0]       lz;
        logic [W-1:0]         res_c;
        logic [2:0]           flg_c;
        lz     = lzc(s2_sum_q[MW-1:0]);
        exp_n  = signed'({2'b00, s2_exp_q});
        mant_n = s2_sum_q[MW-1:0];
        res_c  = POS_ZERO;
        flg_c  = 3'b000;
        if (s2_sum_q[SW-1]) begin
            mant_n = s2_sum_q[SW-1:1];
            exp_n  = exp_n + XW'(1);
        end else begin
            mant_n = s2_sum_q[MW-1:0] << lz;
            exp_n  = exp_n - signed'({{(XW-LZW){1'b0}}, lz});
        end

        if (s2_spec_q) begin
            res_c = s2_spec_res_q;
            flg_c = s2_spec_flg_q;
        end else if (s2_sum_q == {SW{1'b0}}) begin
            res_c = POS_ZERO;
        end else if (exp_n >= signed'(XW'((1 << EXP_WIDTH) - 1))) begin
            res_c = {s2_sign_q, EXP_ONES, FRAC_ZERO};
            flg_c = 3'b100;
        end else if (exp_n <= signed'(XW'(0))) begin
            res_c = POS_ZERO;
            flg_c = 3'b010;
        end else begin
            res_c = {s2_sign_q, exp_n[EXP_WIDTH-1:0], mant_n[FRAC_WIDTH-1:0]};
        end

        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (advance) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                result_d = res_c;
                flags_d  = flg_c;
            end else begin
                result_d = result_q;
                flags_d  = flags_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers; data registers hold whenever the pipe is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_spec_q     <= 1'b0;
            s1_spec_res_q <= POS_ZERO;
            s1_spec_flg_q <= 3'b000;
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_exp_q      <= EXP_ZERO;
            s1_big_q      <= {MW{1'b0}};
            s1_small_q    <= {MW{1'b0}};
            s2_valid_q    <= 1'b0;
            s2_spec_q     <= 1'b0;
            s2_spec_res_q <= POS_ZERO;
            s2_spec_flg_q <= 3'b000;
            s2_sign_q     <= 1'b0;
            s2_exp_q      <= EXP_ZERO;
            s2_sum_q      <= {SW{1'b0}};
            out_valid_q   <= 1'b0;
            result_q      <= POS_ZERO;
            flags_q       <= 3'b000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            if (advance) begin
                s1_spec_q     <= s1_spec_d;
                s1_spec_res_q <= s1_spec_res_d;
                s1_spec_flg_q <= s1_spec_flg_d;
                s1_sign_q     <= s1_sign_d;
                s1_sub_q      <= s1_sub_d;
                s1_exp_q      <= s1_exp_d;
                s1_big_q      <= s1_big_d;
                s1_small_q    <= s1_small_d;
                s2_spec_q     <= s2_spec_d;
                s2_spec_res_q <= s2_spec_res_d;
                s2_spec_flg_q <= s2_spec_flg_d;
                s2_sign_q     <= s2_sign_d;
                s2_exp_q      <= s2_exp_d;
                s2_sum_q      <= s2_sum_d;
            end
        end
    end

endmodule
